mac4_stage: RTL and testbench

- Pipelined multiply-accumulate stage built around the existing combinational 4x4 multiplier `mult4`.
- Accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each 8-bit product.
- Sums the products of one "packet" (terminated by in_last, or by a term limit) and presents the dot-product result downstream over a second valid/ready handshake.
- Sits directly downstream of the operand source and directly consumes `mult4` products.

---
 rtl/mac4_stage_pkg.sv | 13 +
 rtl/mac4_stage_if.sv | 26 ++
 rtl/mac4_stage_mult4.sv | 8 +
 rtl/mac4_stage.sv | 123 ++++++++++++
 tb/tb_mac4_stage.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mac4_stage_pkg.sv
// Shared types and defaults for the mac4_stage multiply-accumulate slice.
package mac4_stage_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam int DEF_ACC_W     = 16;
    localparam int DEF_MAX_TERMS = 16;
    localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/mac4_stage_if.sv
// Operand-in / result-out handshake bundle for mac4_stage.
interface mac4_stage_if #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             overflow;

    modport master (
        output in_valid, a, b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, overflow
    );

    modport slave (
        input  in_valid, a, b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, overflow
    );
endinterface

// File: rtl/mac4_stage_mult4.sv
// Combinational unsigned 4x4 multiplier; output is only ever sampled at clock edges.
module mult4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0, a} * {4'b0, b};
endmodule

// File: rtl/mac4_stage.sv
// Two-stage MAC: registers a*b products, sums them per packet, emits sum/count/overflow.
// Last term accepted at edge N yields out_valid after N+1; one-deep skid stalls input while a result waits.
module mac4_stage
    import mac4_stage_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_TERMS = DEF_MAX_TERMS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    mac4_stage_if.slave  bus
);

    logic [7:0]       prod;
    logic [7:0]       p_reg;
    logic             p_valid;
    logic             p_last;

    state_t           state;
    state_t           state_nxt;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf_acc;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt;
    logic             done_term;

    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic             in_ready;
    logic             accept;
    logic             consume;

    mult4 u_mult4 (
        .a (bus.a),
        .b (bus.b),
        .p (prod)
    );

    always_comb begin
        sum       = {1'b0, acc} + (ACC_W+1)'(p_reg);
        cnt       = count + CNT_W'(1);
        done_term = p_last || (cnt == CNT_W'(MAX_TERMS));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (consume && done_term)           state_nxt = ST_DONE;
            ST_DONE: if (out_valid_q && bus.out_ready)   state_nxt = ST_ACC;
            default:                                     state_nxt = ST_ACC;
        endcase
    end

    // in_ready depends only on registered state, never on in_valid/out_ready.
    always_comb begin
        in_ready = !p_valid || (state == ST_ACC);
        consume  = p_valid && (state == ST_ACC);
    end

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_reg   <= '0;
            p_last  <= 1'b0;
        end else if (accept) begin
            p_valid <= 1'b1;
            p_reg   <= prod;
            p_last  <= bus.in_last;
        end else if (consume) begin
            p_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            ovf_acc     <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (consume) begin
                if (done_term) begin
                    out_sum_q   <= sum[ACC_W-1:0];
                    out_count_q <= cnt;
                    ovf_q       <= ovf_acc | sum[ACC_W];
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    count       <= '0;
                    ovf_acc     <= 1'b0;
                end else begin
                    acc         <= sum[ACC_W-1:0];
                    count       <= cnt;
                    ovf_acc     <= ovf_acc | sum[ACC_W];
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mac4_stage.sv
// Directed bench for mac4_stage built with ACC_W=8, MAX_TERMS=4 so wrap and term-limit cases are reachable.
module tb_mac4_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mac4_stage_if #(.ACC_W(8), .CNT_W(5)) bus ();

    mac4_stage #(.ACC_W(8), .MAX_TERMS(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and return just after the edge that accepts it.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb_, input logic tl);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_;
        bus.in_last  = tl;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_timeout", 16'(n < 50), 16'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] es, input logic [4:0] ec, input logic eo);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
        chk({tag, "_sum"},   16'(bus.out_sum),   16'(es));
        chk({tag, "_count"}, 16'(bus.out_count), 16'(ec));
        chk({tag, "_ovf"},   16'(bus.overflow),  16'(eo));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready",  16'(bus.in_ready),  16'd1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_out_sum",   16'(bus.out_sum),   16'd0);
        chk("rst_out_count", 16'(bus.out_count), 16'd0);
        chk("rst_overflow",  16'(bus.overflow),  16'd0);

        // Single term: result appears exactly one edge after the accept edge.
        bus.out_ready = 1'b1;
        send(4'd15, 4'd15, 1'b1);
        chk("t1_lat_early", 16'(bus.out_valid), 16'd0);
        tick();
        chk("t1_lat_valid", 16'(bus.out_valid), 16'd1);
        check_out("t1", 8'd225, 5'd1, 1'b0);
        tick();
        chk("t1_handshake", 16'(bus.out_valid), 16'd0);

        // Back-to-back dot product: 12 + 30 + 56.
        bus.in_valid = 1'b1; bus.a = 4'd3; bus.b = 4'd4; bus.in_last = 1'b0;
        chk("t2_rdy0", 16'(bus.in_ready), 16'd1);
        tick();
        bus.a = 4'd5; bus.b = 4'd6;
        chk("t2_rdy1", 16'(bus.in_ready), 16'd1);
        tick();
        bus.a = 4'd7; bus.b = 4'd8; bus.in_last = 1'b1;
        chk("t2_rdy2", 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("t2_rdy3", 16'(bus.in_ready), 16'd1);
        check_out("t2", 8'd98, 5'd3, 1'b0);
        tick();

        // Backpressure: result 4/1 held while (1,9) sits in the skid and input stalls.
        bus.out_ready = 1'b0;
        send(4'd2, 4'd2, 1'b1);
        bus.in_valid = 1'b1; bus.a = 4'd1; bus.b = 4'd9; bus.in_last = 1'b0;
        chk("t3_rdy_first", 16'(bus.in_ready), 16'd1);
        tick();
        bus.a = 4'd1; bus.b = 4'd1; bus.in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 16'(bus.out_valid), 16'd1);
            chk("t3_hold_sum",   16'(bus.out_sum),   16'd4);
            chk("t3_hold_count", 16'(bus.out_count), 16'd1);
            chk("t3_stall",      16'(bus.in_ready),  16'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        send(4'd1, 4'd1, 1'b1);
        check_out("t3", 8'd10, 5'd2, 1'b0);
        tick();

        // 225 + 225 = 450 wraps to 194 in 8 bits.
        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b1);
        check_out("t4", 8'd194, 5'd2, 1'b1);
        tick();
        send(4'd1, 4'd1, 1'b1);
        check_out("t4_clear", 8'd1, 5'd1, 1'b0);
        tick();

        // Term limit of 4: fifth term opens the next packet.
        for (int i = 0; i < 5; i++) send(4'd1, 4'd1, 1'b0);
        check_out("t5_limit", 8'd4, 5'd4, 1'b0);
        tick();
        send(4'd1, 4'd1, 1'b1);
        check_out("t5_next", 8'd2, 5'd2, 1'b0);
        tick();

        // Reset mid-packet discards the partial sum.
        send(4'd9, 4'd9, 1'b0);
        chk("t6_pre0", 16'(bus.out_valid), 16'd0);
        send(4'd2, 4'd3, 1'b0);
        chk("t6_pre1", 16'(bus.out_valid), 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 16'(bus.out_valid), 16'd0);
        chk("t6_rst_rdy",   16'(bus.in_ready),  16'd1);
        chk("t6_rst_count", 16'(bus.out_count), 16'd0);
        send(4'd1, 4'd2, 1'b1);
        check_out("t6", 8'd2, 5'd1, 1'b0);
        tick();
        chk("t6_idle", 16'(bus.out_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
